pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 47 ++++
 rtl/pipe_entry.sv | 48 ++++
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the inter-stage pipeline registers of the core.
// Each stage boundary gets packed structs so that instances size their widths with $bits.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 112;

  // Decode/Execute boundary control: 16 bits in total.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_control;
    logic [3:0] cond;
    logic [1:0] flag_write;
    logic       no_write;
  } de_ctrl_t;

  // Decode/Execute boundary data: 112 bits in total.
  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext_imm;
    logic [3:0]  wa3;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  shamt;
  } de_data_t;

  function automatic logic [1:0] state_occupancy(pipe_state_e st);
    case (st)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One ctrl+data storage slot of a pipeline register.
// Clear takes priority over load. Data is only wiped on clear when CLEAR_DATA is set.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (clear_i) begin
      ctrl_d = '0;
      if (CLEAR_DATA) data_d = '0;
    end else if (load_i) begin
      ctrl_d = ctrl_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with a 2-entry skid buffer so in_ready is a flop.
// Flush empties the stage and zeroes the control of every held entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        in_fire, out_fire;
  logic        main_load, main_from_skid, skid_load;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_ready) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Registered ready: only a full skid buffer blocks the next cycle's input.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_entry #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load_i (main_load),
    .clear_i(flush),
    .ctrl_i (main_ctrl_in),
    .data_i (main_data_in),
    .ctrl_o (main_ctrl),
    .data_o (main_data)
  );

  pipe_entry #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load_i (skid_load),
    .clear_i(flush),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .ctrl_o (skid_ctrl),
    .data_o (skid_data)
  );

  assign in_ready  = in_ready_q;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state_occupancy(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: hand-derived vector table, flush/reset corner sequences,
// and a randomised run against a queue reference model. Two instances differ only in CLEAR_DATA.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = $bits(de_ctrl_t);
  localparam int DW = $bits(de_data_t);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, inValid, outReady;
  logic [CW-1:0] inCtrl;
  logic [DW-1:0] inData;

  logic          inReady, outValid, inReadyC, outValidC;
  logic [CW-1:0] outCtrl, outCtrlC;
  logic [DW-1:0] outData, outDataC;
  logic [1:0]    occ, occC;

  int vectorsApplied = 0;
  int miscompares    = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReady),
    .in_ctrl(inCtrl), .in_data(inData), .out_valid(outValid), .out_ready(outReady),
    .out_ctrl(outCtrl), .out_data(outData), .occupancy(occ)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dutC (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReadyC),
    .in_ctrl(inCtrl), .in_data(inData), .out_valid(outValidC), .out_ready(outReady),
    .out_ctrl(outCtrlC), .out_data(outDataC), .occupancy(occC)
  );

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          fl;
    logic [CW-1:0] ctrl;
    logic          expOv;
    logic [CW-1:0] expCtrl;
    logic          expIr;
    logic [1:0]    expOcc;
  } vec_t;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  vec_t   vecs[$];
  entry_t modelQ[$];

  function automatic logic [DW-1:0] mkData(logic [CW-1:0] c);
    return {c, ~c, c, 16'h1234, c, ~c, c};
  endfunction

  function automatic void addVec(logic iv, logic ordy, logic fl, logic [CW-1:0] c,
                                 logic eov, logic [CW-1:0] ec, logic eir, logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.ctrl = c;
    v.expOv = eov; v.expCtrl = ec; v.expIr = eir; v.expOcc = eocc;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(logic iv, logic ordy, logic fl, logic [CW-1:0] c, logic [DW-1:0] d);
    inValid  = iv;
    outReady = ordy;
    flush    = fl;
    inCtrl   = c;
    inData   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBoth(string tag, logic eov, logic [CW-1:0] ec, logic eir, logic [1:0] eocc);
    checkOutput({tag, ".out_valid"}, DW'(outValid), DW'(eov));
    checkOutput({tag, ".out_ctrl"},  DW'(outCtrl),  DW'(ec));
    checkOutput({tag, ".in_ready"},  DW'(inReady),  DW'(eir));
    checkOutput({tag, ".occupancy"}, DW'(occ),      DW'(eocc));
    checkOutput({tag, ".C.out_valid"}, DW'(outValidC), DW'(eov));
    checkOutput({tag, ".C.out_ctrl"},  DW'(outCtrlC),  DW'(ec));
    checkOutput({tag, ".C.in_ready"},  DW'(inReadyC),  DW'(eir));
    checkOutput({tag, ".C.occupancy"}, DW'(occC),      DW'(eocc));
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #2;
    checkBoth("reset", 1'b0, '0, 1'b1, 2'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic iv, ordy, fl, mReady, mOv;
    logic [CW-1:0] seq;
    entry_t e;

    doReset();

    // streaming, stall with skid fill, flush of a full stage with same-cycle input
    for (int i = 1; i <= 5; i++)
      addVec(1, 1, 0, CW'(i), 1, CW'(i), 1, 2'd1);
    addVec(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 2'd0);
    addVec(1, 0, 0, 16'h00A1, 1, 16'h00A1, 1, 2'd1);
    addVec(1, 0, 0, 16'h00A2, 1, 16'h00A1, 0, 2'd2);
    addVec(1, 0, 0, 16'h00A3, 1, 16'h00A1, 0, 2'd2);
    addVec(1, 1, 0, 16'h00A3, 1, 16'h00A2, 1, 2'd1);
    addVec(1, 1, 0, 16'h00A3, 1, 16'h00A3, 1, 2'd1);
    addVec(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 2'd0);
    addVec(1, 0, 0, 16'h00B1, 1, 16'h00B1, 1, 2'd1);
    addVec(1, 0, 0, 16'h00B2, 1, 16'h00B1, 0, 2'd2);
    addVec(1, 0, 1, 16'h00B3, 0, 16'h0000, 1, 2'd0);
    addVec(0, 1, 0, 16'h00B3, 0, 16'h0000, 1, 2'd0);
    addVec(1, 1, 1, 16'h00C1, 0, 16'h0000, 1, 2'd0);
    addVec(1, 1, 1, 16'h00C2, 0, 16'h0000, 1, 2'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].ctrl, mkData(vecs[i].ctrl));
      step();
      checkBoth($sformatf("vec%0d", i), vecs[i].expOv, vecs[i].expCtrl, vecs[i].expIr, vecs[i].expOcc);
      if (vecs[i].expOv)
        checkOutput($sformatf("vec%0d.out_data", i), outData, mkData(vecs[i].expCtrl));
    end

    // flushed data survives only when CLEAR_DATA=0
    applyStimulus(1, 0, 0, 16'h000C, DW'(32'hDEAD_BEEF));
    step();
    checkOutput("dataHeld.out_data",   outData,  DW'(32'hDEAD_BEEF));
    checkOutput("dataHeld.C.out_data", outDataC, DW'(32'hDEAD_BEEF));
    applyStimulus(0, 0, 1, '0, '0);
    step();
    checkBoth("dataFlush", 1'b0, '0, 1'b1, 2'd0);
    checkOutput("dataFlush.out_data",   outData,  DW'(32'hDEAD_BEEF));
    checkOutput("dataFlush.C.out_data", outDataC, '0);

    // asynchronous reset while the skid buffer is full
    applyStimulus(1, 0, 0, 16'h00D1, mkData(16'h00D1));
    step();
    applyStimulus(1, 0, 0, 16'h00D2, mkData(16'h00D2));
    step();
    checkBoth("preReset", 1'b1, 16'h00D1, 1'b0, 2'd2);
    #3 reset = 1'b0;
    #1 checkBoth("asyncReset", 1'b0, '0, 1'b1, 2'd0);
    checkOutput("asyncReset.out_data", outData, '0);
    #2 reset = 1'b1;
    applyStimulus(0, 1, 0, '0, '0);
    step();
    checkBoth("postReset", 1'b0, '0, 1'b1, 2'd0);

    // randomised traffic against the queue model
    seq = 16'h1000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      iv     = ($urandom_range(0, 9) < 7);
      ordy   = ($urandom_range(0, 9) < 6);
      fl     = ($urandom_range(0, 19) == 0);
      e.ctrl = seq;
      e.data = {$urandom, $urandom, $urandom, seq};
      applyStimulus(iv, ordy, fl, e.ctrl, e.data);
      mReady = (modelQ.size() < 2);
      mOv    = (modelQ.size() > 0);
      if (fl) begin
        modelQ.delete();
      end else begin
        if (mOv && ordy) void'(modelQ.pop_front());
        if (iv && mReady) begin
          modelQ.push_back(e);
          seq++;
        end
      end
      step();
      checkOutput("rnd.out_valid", DW'(outValid), DW'(modelQ.size() > 0));
      checkOutput("rnd.occupancy", DW'(occ), DW'(modelQ.size()));
      checkOutput("rnd.in_ready",  DW'(inReady), DW'(modelQ.size() < 2));
      if (modelQ.size() > 0) begin
        checkOutput("rnd.out_ctrl", DW'(outCtrl), DW'(modelQ[0].ctrl));
        checkOutput("rnd.out_data", outData, modelQ[0].data);
        checkOutput("rnd.C.out_data", outDataC, modelQ[0].data);
      end else begin
        checkOutput("rnd.out_ctrl.idle", DW'(outCtrl), '0);
        checkOutput("rnd.C.out_ctrl.idle", DW'(outCtrlC), '0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
